// File: rtl/axa_pkg.sv
// rtl/axa_pkg.sv - AXA shared opcode fields, opcodes and front-end defaults
package axa_pkg;

    localparam int PC_W_DEF  = 16;
    localparam int DRAIN_DEF = 3;

    localparam int IR_W = 16;
    localparam int OP_W = 6;

    // Long-form opcodes live in ir[15:10]; short-form (ir[15]==0) only use ir[15:12].
    localparam int OP_HI       = 15;
    localparam int OP_LO       = 10;
    localparam int OP_SHORT_LO = 12;

    localparam logic [OP_W-1:0] OP_SYS  = 6'b111000;
    localparam logic [OP_W-1:0] OP_FAIL = 6'b110001;
    localparam logic [OP_W-1:0] OP_NOP  = 6'b111010;
    localparam logic [2:0]      BR_GROUP = 3'b101;

    localparam logic [IR_W-1:0] NOP_INSN = {OP_NOP, 10'b0};

    function automatic logic [OP_W-1:0] op_of(input logic [IR_W-1:0] ir);
        if (ir[OP_HI]) begin
            return ir[OP_HI:OP_LO];
        end
        return {ir[OP_HI:OP_SHORT_LO], 2'b00};
    endfunction

endpackage

// File: rtl/axa_op_class.sv
// rtl/axa_op_class.sv - combinational opcode classifier for an AXA instruction word
//  ir          in   16  instruction word
//  op          out  6   normalised opcode
//  is_branch   out  1   opcode in the branch group
//  is_blocking out  1   sys or fail: pipeline must drain behind it
module axa_op_class
    import axa_pkg::*;
(
    input  logic [IR_W-1:0] ir,
    output logic [OP_W-1:0] op,
    output logic            is_branch,
    output logic            is_blocking
);

    always_comb begin
        op          = op_of(ir);
        is_branch   = (op[OP_W-1:OP_W-3] == BR_GROUP);
        is_blocking = (op == OP_SYS) || (op == OP_FAIL);
    end

endmodule

// File: rtl/axa_fetch.sv
// rtl/axa_fetch.sv - AXA front end: PC update and instruction fetch (stages 0-1)
//  clk, reset            clock, synchronous active-high reset
//  imem_addr / imem_data instruction memory address (= pc) and same-cycle data
//  stall                 hold pc and outputs (drain counter still runs)
//  dir_rev               reverse execution: pc steps -1, issued fwd flag 0
//  br_in_s2              branch op in stage 2: hold a shadow bubble
//  redirect_en/_pc       taken branch target from stage 2
//  flush_en/_pc          jerr flush restart address (overrides redirect and stall)
//  ir_q, lastpc_q, fwd_q registered instruction, preceding pc, issue direction
module axa_fetch
    import axa_pkg::*;
#(
    parameter int DRAIN = DRAIN_DEF,
    parameter int PC_W  = PC_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] imem_addr,
    input  logic [IR_W-1:0] imem_data,
    input  logic            stall,
    input  logic            dir_rev,
    input  logic            br_in_s2,
    input  logic            redirect_en,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            flush_en,
    input  logic [PC_W-1:0] flush_pc,
    output logic [IR_W-1:0] ir_q,
    output logic [PC_W-1:0] lastpc_q,
    output logic            fwd_q
);

    localparam int DCW = (DRAIN < 1) ? 1 : $clog2(DRAIN + 1);
    localparam logic [DCW-1:0]  DRAIN_LOAD = DCW'(DRAIN);
    localparam logic [DCW-1:0]  DRAIN_ONE  = DCW'(1);
    localparam logic [PC_W-1:0] PC_ONE     = PC_W'(1);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] lastpc;
    logic [DCW-1:0]  drain_cnt;

    logic [OP_W-1:0] ir_op;
    logic            br_local;
    logic            blk;
    logic            unused_op;
    logic [PC_W-1:0] pc_next_step;

    axa_op_class u_op_class (
        .ir          (ir_q),
        .op          (ir_op),
        .is_branch   (br_local),
        .is_blocking (blk)
    );

    // The full opcode is for decode; fetch only needs the two class flags.
    assign unused_op = ^ir_op;

    assign imem_addr    = pc;
    assign pc_next_step = dir_rev ? (pc - PC_ONE) : (pc + PC_ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= '0;
            lastpc    <= '0;
            ir_q      <= NOP_INSN;
            lastpc_q  <= '0;
            fwd_q     <= 1'b1;
            drain_cnt <= '0;
        end else if (flush_en) begin
            pc        <= flush_pc;
            lastpc    <= flush_pc;
            ir_q      <= NOP_INSN;
            drain_cnt <= '0;
        end else if (redirect_en) begin
            // lastpc is pc-1 regardless of direction: land after a jump
            // reports the slot just behind the branch's successor.
            pc     <= redirect_pc;
            lastpc <= pc - PC_ONE;
            if (!stall) begin
                ir_q <= NOP_INSN;
            end
        end else if (stall) begin
            // Downstream drain keeps counting while fetch is frozen.
            if (drain_cnt != '0) begin
                drain_cnt <= drain_cnt - DRAIN_ONE;
            end
        end else if (blk) begin
            ir_q      <= NOP_INSN;
            drain_cnt <= DRAIN_LOAD;
        end else if (drain_cnt != '0) begin
            ir_q      <= NOP_INSN;
            drain_cnt <= drain_cnt - DRAIN_ONE;
        end else if (br_local || br_in_s2) begin
            ir_q <= NOP_INSN;
        end else begin
            ir_q     <= imem_data;
            lastpc_q <= lastpc;
            fwd_q    <= !dir_rev;
            lastpc   <= pc;
            pc       <= pc_next_step;
        end
    end

endmodule

// File: tb/tb_axa_fetch.sv
// tb/tb_axa_fetch.sv - self-checking bench for axa_fetch
module tb_axa_fetch;

    localparam int          DRAIN = 3;
    localparam logic [15:0] NOP   = 16'hE800;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        dir_rev;
    logic        br_in_s2;
    logic        redirect_en;
    logic [15:0] redirect_pc;
    logic        flush_en;
    logic [15:0] flush_pc;
    logic [15:0] ir_q;
    logic [15:0] lastpc_q;
    logic        fwd_q;

    logic [15:0] mem [0:65535];

    int n_checks = 0;
    int n_fail   = 0;

    int          m_pc;
    int          m_lastpc;
    int          m_lastpc_q;
    int          m_drain;
    logic [15:0] m_ir;
    logic        m_fwd;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    axa_fetch #(
        .DRAIN (DRAIN),
        .PC_W  (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .stall       (stall),
        .dir_rev     (dir_rev),
        .br_in_s2    (br_in_s2),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .flush_en    (flush_en),
        .flush_pc    (flush_pc),
        .ir_q        (ir_q),
        .lastpc_q    (lastpc_q),
        .fwd_q       (fwd_q)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] opcode(input logic [15:0] w);
        return w[15] ? w[15:10] : {w[15:12], 2'b00};
    endfunction

    // Reference: one clock edge of the fetch unit, taken from the priority list.
    task automatic model_edge();
        logic [5:0] op;
        bit         shadow;
        bit         halt;
        op     = opcode(m_ir);
        shadow = (op[5:3] == 3'b101) || br_in_s2;
        halt   = (op == 6'b111000) || (op == 6'b110001);
        if (reset) begin
            m_pc = 0; m_lastpc = 0; m_ir = NOP; m_lastpc_q = 0; m_fwd = 1'b1; m_drain = 0;
        end else if (flush_en) begin
            m_pc = int'(flush_pc); m_lastpc = int'(flush_pc); m_ir = NOP; m_drain = 0;
        end else if (redirect_en) begin
            m_lastpc = (m_pc + 65535) % 65536;
            m_pc     = int'(redirect_pc);
            if (!stall) m_ir = NOP;
        end else if (stall) begin
            if (m_drain > 0) m_drain--;
        end else if (halt) begin
            m_ir = NOP; m_drain = DRAIN;
        end else if (m_drain > 0) begin
            m_ir = NOP; m_drain--;
        end else if (shadow) begin
            m_ir = NOP;
        end else begin
            m_ir       = mem[m_pc];
            m_lastpc_q = m_lastpc;
            m_fwd      = !dir_rev;
            m_lastpc   = m_pc;
            m_pc       = (m_pc + (dir_rev ? 65535 : 1)) % 65536;
        end
    endtask

    task automatic tick();
        check("imem_addr", {16'h0, imem_addr}, m_pc);
        model_edge();
        @(posedge clk);
        #1;
        check("ir_q", {16'h0, ir_q}, {16'h0, m_ir});
        check("lastpc_q", {16'h0, lastpc_q}, m_lastpc_q);
        check("fwd_q", {31'h0, fwd_q}, {31'h0, m_fwd});
    endtask

    task automatic idle();
        reset = 1'b0; stall = 1'b0; br_in_s2 = 1'b0;
        redirect_en = 1'b0; redirect_pc = '0; flush_en = 1'b0; flush_pc = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        dir_rev = 1'b0;
        @(posedge clk);
        #1;
        m_pc = 0; m_lastpc = 0; m_ir = NOP; m_lastpc_q = 0; m_fwd = 1'b1; m_drain = 0;
        tick();
        check("rst_ir", {16'h0, ir_q}, {16'h0, NOP});
        check("rst_lastpc", {16'h0, lastpc_q}, 32'h0);
        check("rst_fwd", {31'h0, fwd_q}, 32'h1);
        check("rst_addr", {16'h0, imem_addr}, 32'h0);
        reset = 1'b0;
    endtask

    task automatic flush_to(input logic [15:0] a);
        flush_en = 1'b1;
        flush_pc = a;
        tick();
        flush_en = 1'b0;
    endtask

    initial begin
        logic [15:0] t1w [4];
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        t1w[0] = 16'h1234; t1w[1] = 16'h8C01; t1w[2] = 16'h9005; t1w[3] = 16'hE000;
        for (int i = 0; i < 4; i++) mem[i] = t1w[i];
        dir_rev = 1'b0;
        idle();

        // T1: straight-line fetch into a sys, then 1+DRAIN bubbles with pc held
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_ir", {16'h0, ir_q}, {16'h0, t1w[i]});
        end
        for (int i = 0; i < 1 + DRAIN; i++) begin
            tick();
            check("t1_nop", {16'h0, ir_q}, {16'h0, NOP});
            check("t1_pc", {16'h0, imem_addr}, 32'd4);
        end
        tick();
        check("t1_resume", {16'h0, imem_addr}, 32'd5);

        // T2: reverse stepping
        mem[6] = 16'h0006; mem[5] = 16'h0005; mem[4] = 16'h0004; mem[3] = 16'h0003;
        flush_to(16'd6);
        dir_rev = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_ir", {16'h0, ir_q}, 32'd5 - i);
            check("t2_lastpc", {16'h0, lastpc_q}, 32'd6 - i);
            check("t2_fwd", {31'h0, fwd_q}, 32'h0);
        end

        // T3: branch shadow bubbles then redirect
        dir_rev = 1'b0;
        mem[7] = 16'hA000; mem[20] = 16'h0214;
        flush_to(16'd6);
        tick();
        tick();
        check("t3_bz", {16'h0, ir_q}, 32'hA000);
        tick();
        check("t3_shadow1", {16'h0, ir_q}, {16'h0, NOP});
        br_in_s2 = 1'b1;
        tick();
        check("t3_shadow2", {16'h0, ir_q}, {16'h0, NOP});
        check("t3_pc_hold", {16'h0, imem_addr}, 32'd8);
        redirect_en = 1'b1; redirect_pc = 16'd20;
        tick();
        redirect_en = 1'b0; br_in_s2 = 1'b0;
        tick();
        check("t3_target", {16'h0, ir_q}, 32'h0214);
        check("t3_lastpc", {16'h0, lastpc_q}, 32'd7);
        check("t3_addr", {16'h0, imem_addr}, 32'd21);

        // T4: stall freezes everything
        mem[9] = 16'h0009; mem[10] = 16'h000A;
        flush_to(16'd9);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_ir", {16'h0, ir_q}, 32'h0009);
            check("t4_lastpc", {16'h0, lastpc_q}, 32'd9);
            check("t4_addr", {16'h0, imem_addr}, 32'd10);
        end
        stall = 1'b0;
        tick();
        check("t4_resume", {16'h0, ir_q}, 32'h000A);

        // T5: flush during drain and stall
        mem[16'h28] = 16'hC400; mem[16'h30] = 16'h0330;
        flush_to(16'h28);
        tick();
        tick();
        tick();
        stall = 1'b1;
        flush_en = 1'b1; flush_pc = 16'h30;
        tick();
        check("t5_nop", {16'h0, ir_q}, {16'h0, NOP});
        check("t5_pc", {16'h0, imem_addr}, 32'h30);
        stall = 1'b0; flush_en = 1'b0;
        tick();
        check("t5_nodrain", {16'h0, ir_q}, 32'h0330);

        // T6: wraparound both ways, reset mid-stream and mid-drain
        mem[16'hFFFF] = 16'h0FFF;
        flush_to(16'hFFFF);
        tick();
        check("t6_wrap_fwd", {16'h0, imem_addr}, 32'h0);
        flush_to(16'h0000);
        dir_rev = 1'b1;
        tick();
        check("t6_wrap_rev", {16'h0, imem_addr}, 32'hFFFF);
        dir_rev = 1'b0;
        stall = 1'b1;
        reset = 1'b1;
        tick();
        check("t6_rst_ir", {16'h0, ir_q}, {16'h0, NOP});
        check("t6_rst_lastpc", {16'h0, lastpc_q}, 32'h0);
        check("t6_rst_fwd", {31'h0, fwd_q}, 32'h1);
        check("t6_rst_addr", {16'h0, imem_addr}, 32'h0);
        reset = 1'b0; stall = 1'b0;
        mem[16'h40] = 16'hE000;
        flush_to(16'h40);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("t6_drain_clr", {16'h0, ir_q}, {16'h0, mem[0]});

        // Randomised run against the reference model
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 199) == 0);
            stall       = ($urandom_range(0, 99) < 20);
            br_in_s2    = ($urandom_range(0, 99) < 10);
            redirect_en = ($urandom_range(0, 99) < 5);
            redirect_pc = 16'($urandom);
            flush_en    = ($urandom_range(0, 99) < 3);
            flush_pc    = 16'($urandom);
            if ($urandom_range(0, 99) < 5) dir_rev = ~dir_rev;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
